// File: rtl/intra_pred_nxn_if.sv
// ============================================================================
// Module      : intra_pred_nxn_if
// Description : Request/edge inputs and row-stream outputs of intra_pred_nxn.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface intra_pred_nxn_if #(
    parameter int BLK = 8,
    parameter int PW  = 8
);
    logic                    start;
    logic [1:0]              mode;
    logic                    top_avail;
    logic                    left_avail;
    logic [BLK*PW-1:0]       toppixels;
    logic [BLK*PW-1:0]       leftpixels;
    logic [BLK*PW-1:0]       out_row;
    logic                    out_valid;
    logic                    out_ready;
    logic [$clog2(BLK)-1:0]  out_row_idx;
    logic                    out_last;
    logic                    busy;
    logic                    done;

    modport master (
        output start, mode, top_avail, left_avail, toppixels, leftpixels, out_ready,
        input  out_row, out_valid, out_row_idx, out_last, busy, done
    );

    modport slave (
        input  start, mode, top_avail, left_avail, toppixels, leftpixels, out_ready,
        output out_row, out_valid, out_row_idx, out_last, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/intra_pred_nxn.sv
// ============================================================================
// Module      : intra_pred_nxn
// Description : NxN intra predictor (vertical / horizontal / DC), one row per
//               handshake. Define INTRA_PRED_DC_ROUND_EN for rounded DC.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module intra_pred_nxn #(
    parameter int BLK = 8,
    parameter int PW  = 8
) (
    input  logic               clk,
    input  logic               reset,
    intra_pred_nxn_if.slave    bus
);
    localparam int RW       = $clog2(BLK);
    localparam int LOG_ONE  = $clog2(BLK);
    localparam int LOG_TWO  = $clog2(2 * BLK);
    localparam int AW       = PW + LOG_TWO;

    localparam logic [RW-1:0] c_last_idx = RW'(BLK - 1);
    localparam logic [PW-1:0] c_mid      = {1'b1, {(PW-1){1'b0}}};
`ifdef INTRA_PRED_DC_ROUND_EN
    localparam logic [AW-1:0] c_rnd_two  = AW'(BLK);
    localparam logic [AW-1:0] c_rnd_one  = AW'(BLK / 2);
`else
    localparam logic [AW-1:0] c_rnd_two  = '0;
    localparam logic [AW-1:0] c_rnd_one  = '0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [BLK*PW-1:0]  r_top;
    logic [BLK*PW-1:0]  r_left;
    logic [1:0]         r_mode;
    logic               r_top_av;
    logic               r_left_av;
    logic [AW-1:0]      r_acc;
    logic [RW-1:0]      r_k;
    logic [RW-1:0]      r_row;
    logic               r_done;

    logic               w_accept;
    logic               w_acc_last;
    logic [AW-1:0]      w_add_top;
    logic [AW-1:0]      w_add_left;
    logic [PW-1:0]      w_dc;
    logic [PW-1:0]      w_left_r;
    logic [BLK*PW-1:0]  w_row;

    assign w_accept   = (r_state == ST_EMIT) && bus.out_ready;
    assign w_acc_last = (r_k == c_last_idx);
    assign w_add_top  = r_top_av  ? {{(AW-PW){1'b0}}, r_top[r_k*PW +: PW]}  : '0;
    assign w_add_left = r_left_av ? {{(AW-PW){1'b0}}, r_left[r_k*PW +: PW]} : '0;
    assign w_left_r   = r_left[r_row*PW +: PW];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_next = bus.mode[1] ? ST_ACC : ST_EMIT;
            ST_ACC:  if (w_acc_last) w_next = ST_EMIT;
            ST_EMIT: if (w_accept && (r_row == c_last_idx)) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Captured edges are only written from IDLE, so a start while busy is inert.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_top     <= '0;
            r_left    <= '0;
            r_mode    <= '0;
            r_top_av  <= 1'b0;
            r_left_av <= 1'b0;
            r_acc     <= '0;
            r_k       <= '0;
            r_row     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_top     <= bus.toppixels;
                        r_left    <= bus.leftpixels;
                        r_mode    <= bus.mode;
                        r_top_av  <= bus.top_avail;
                        r_left_av <= bus.left_avail;
                        r_acc     <= '0;
                        r_k       <= '0;
                        r_row     <= '0;
                    end
                end
                ST_ACC: begin
                    r_acc <= r_acc + w_add_top + w_add_left;
                    r_k   <= r_k + 1'b1;
                end
                ST_EMIT: begin
                    if (w_accept) begin
                        r_row <= r_row + 1'b1;
                        if (r_row == c_last_idx) r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The accumulator width leaves headroom for the rounding term.
    always_comb begin
        w_dc = c_mid;
        if (r_top_av && r_left_av) begin
            w_dc = PW'((r_acc + c_rnd_two) >> LOG_TWO);
        end else if (r_top_av || r_left_av) begin
            w_dc = PW'((r_acc + c_rnd_one) >> LOG_ONE);
        end
    end

    always_comb begin
        w_row = '0;
        for (int c = 0; c < BLK; c++) begin
            if (r_mode == 2'd0) begin
                w_row[c*PW +: PW] = r_top_av ? r_top[c*PW +: PW] : c_mid;
            end else if (r_mode == 2'd1) begin
                w_row[c*PW +: PW] = r_left_av ? w_left_r : c_mid;
            end else begin
                w_row[c*PW +: PW] = w_dc;
            end
        end
    end

    assign bus.out_valid   = (r_state == ST_EMIT);
    assign bus.out_row     = (r_state == ST_EMIT) ? w_row : '0;
    assign bus.out_row_idx = r_row;
    assign bus.out_last    = (r_state == ST_EMIT) && (r_row == c_last_idx);
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.done        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_intra_pred_nxn.sv
// ============================================================================
// Module      : tb_intra_pred_nxn
// Description : Self-checking bench for intra_pred_nxn at BLK = 4, 8 and 16.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_intra_pred_nxn;
    localparam int PW = 8;
`ifdef INTRA_PRED_DC_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    intra_pred_nxn_if #(.BLK(8),  .PW(PW)) b8  ();
    intra_pred_nxn_if #(.BLK(4),  .PW(PW)) b4  ();
    intra_pred_nxn_if #(.BLK(16), .PW(PW)) b16 ();

    intra_pred_nxn #(.BLK(8),  .PW(PW)) dut8  (.clk(clk), .reset(rst_n), .bus(b8.slave));
    intra_pred_nxn #(.BLK(4),  .PW(PW)) dut4  (.clk(clk), .reset(rst_n), .bus(b4.slave));
    intra_pred_nxn #(.BLK(16), .PW(PW)) dut16 (.clk(clk), .reset(rst_n), .bus(b16.slave));

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: the request as the bench understands it.
    int m_top[16];
    int m_left[16];
    int m_mode;
    int m_blk;
    bit m_tav;
    bit m_lav;

    typedef struct {
        int mode; int tav; int lav;
        int tb; int ts; int lb; int ls;
        int lat; int p00; int p77;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_pix(int r, int c);
        int sum;
        sum = 0;
        if (m_mode == 0) return m_tav ? m_top[c] : 128;
        if (m_mode == 1) return m_lav ? m_left[r] : 128;
        for (int k = 0; k < m_blk; k++) begin
            if (m_tav) sum += m_top[k];
            if (m_lav) sum += m_left[k];
        end
        if (m_tav && m_lav) return (sum + (RND ? m_blk : 0)) / (2 * m_blk);
        if (m_tav || m_lav) return (sum + (RND ? m_blk / 2 : 0)) / m_blk;
        return 128;
    endfunction

    function automatic logic [127:0] exp_row(int r);
        logic [127:0] v;
        v = '0;
        for (int c = 0; c < m_blk; c++) v[c*8 +: 8] = 8'(exp_pix(r, c));
        return v;
    endfunction

    task automatic scramble8();
        b8.toppixels  = {$urandom, $urandom};
        b8.leftpixels = {$urandom, $urandom};
        b8.mode       = 2'($urandom_range(0, 3));
        b8.top_avail  = 1'($urandom_range(0, 1));
        b8.left_avail = 1'($urandom_range(0, 1));
    endtask

    // Entered and left on a negedge; the request is driven immediately, so
    // back-to-back calls place the new start in the cycle done is high.
    task automatic run8(input bit rand_ready, input bit inject, input int exp_lat,
                        output logic [7:0] p00, output logic [7:0] p77);
        int  lat;
        int  r;
        int  cyc;
        bit  rdy;
        p00 = '0;
        p77 = '0;
        m_blk = 8;
        b8.mode       = 2'(m_mode);
        b8.top_avail  = m_tav;
        b8.left_avail = m_lav;
        for (int c = 0; c < 8; c++) begin
            b8.toppixels[c*8 +: 8]  = 8'(m_top[c]);
            b8.leftpixels[c*8 +: 8] = 8'(m_left[c]);
        end
        b8.start     = 1'b1;
        b8.out_ready = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) chk("done_one_cycle", b8.done, 1'b0);
            b8.start = inject && (lat == 3);
            scramble8();
        end while (!b8.out_valid && lat < 40);
        chk("first_valid_latency", lat, exp_lat);
        r = 0;
        cyc = 0;
        while (r < 8 && cyc < 200) begin
            chk("row_valid", b8.out_valid, 1'b1);
            chk("row_idx", b8.out_row_idx, r);
            chk("row_last", b8.out_last, r == 7);
            chk("row_data", b8.out_row, exp_row(r));
            if (r == 0) p00 = b8.out_row[7:0];
            if (r == 7) p77 = b8.out_row[63:56];
            rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            b8.out_ready = rdy;
            b8.start     = inject && (cyc == 3);
            scramble8();
            @(negedge clk);
            cyc++;
            if (rdy) r++;
        end
        if (cyc >= 200) chk("emit_timeout", 0, 1);
        b8.start     = 1'b0;
        b8.out_ready = 1'b0;
        chk("done_pulse", b8.done, 1'b1);
        chk("valid_drop", b8.out_valid, 1'b0);
        chk("idle_after_last", b8.busy, 1'b0);
    endtask

    task automatic run4(input bit tav, input bit lav, input int exp_dc);
        int lat;
        logic [31:0] e;
        for (int c = 0; c < 4; c++) e[c*8 +: 8] = 8'(exp_dc);
        b4.mode = 2'd2;
        b4.top_avail = tav;
        b4.left_avail = lav;
        b4.toppixels = {4{8'd200}};
        b4.leftpixels = {8'd4, 8'd3, 8'd2, 8'd1};
        b4.start = 1'b1;
        b4.out_ready = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            b4.start = 1'b0;
        end while (!b4.out_valid && lat < 40);
        chk("blk4_latency", lat, 5);
        b4.out_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            chk("blk4_valid", b4.out_valid, 1'b1);
            chk("blk4_row", b4.out_row, e);
            chk("blk4_last", b4.out_last, r == 3);
            @(negedge clk);
        end
        b4.out_ready = 1'b0;
        chk("blk4_done", b4.done, 1'b1);
    endtask

    task automatic run16_stall();
        int got;
        int lat;
        bit rdy;
        bit stalled;
        logic [127:0] prow;
        logic [127:0] e;
        logic [3:0] pidx;
        got = 0; rdy = 1'b1; stalled = 1'b0; prow = '0; pidx = '0;
        b16.mode = 2'd1;
        b16.top_avail = 1'b0;
        b16.left_avail = 1'b1;
        b16.toppixels = '0;
        for (int k = 0; k < 16; k++) b16.leftpixels[k*8 +: 8] = 8'(k * 3);
        b16.start = 1'b1;
        b16.out_ready = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            b16.start = 1'b0;
            b16.leftpixels = {$urandom, $urandom, $urandom, $urandom};
        end while (!b16.out_valid && lat < 40);
        chk("blk16_latency", lat, 1);
        for (int cyc = 0; cyc < 80 && got < 16; cyc++) begin
            chk("blk16_valid", b16.out_valid, 1'b1);
            if (stalled) begin
                chk("blk16_stall_row", b16.out_row, prow);
                chk("blk16_stall_idx", b16.out_row_idx, pidx);
            end
            for (int c = 0; c < 16; c++) e[c*8 +: 8] = 8'(got * 3);
            chk("blk16_idx", b16.out_row_idx, got);
            chk("blk16_row", b16.out_row, e);
            chk("blk16_last", b16.out_last, got == 15);
            prow = b16.out_row;
            pidx = b16.out_row_idx;
            b16.out_ready = rdy;
            stalled = !rdy;
            @(negedge clk);
            if (rdy) got++;
            rdy = !rdy;
        end
        b16.out_ready = 1'b0;
        chk("blk16_rows_accepted", got, 16);
        chk("blk16_done", b16.done, 1'b1);
        chk("blk16_valid_drop", b16.out_valid, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, b8.out_valid, 1'b0);
        chk({tag, "_row"}, b8.out_row, '0);
        chk({tag, "_idx"}, b8.out_row_idx, '0);
        chk({tag, "_last"}, b8.out_last, 1'b0);
        chk({tag, "_busy"}, b8.busy, 1'b0);
        chk({tag, "_done"}, b8.done, 1'b0);
    endtask

    initial begin : main
        vec_t tbl[9];
        logic [7:0] p00;
        logic [7:0] p77;
        int waited;

        tbl[0] = '{0, 1, 0,   0, 1,   0, 0,  1,   0,   7};
        tbl[1] = '{2, 1, 1, 255, 0, 255, 0,  9, 255, 255};
        tbl[2] = '{2, 1, 1,  10, 0,  11, 0,  9, RND ? 11 : 10, RND ? 11 : 10};
        tbl[3] = '{1, 0, 1,   0, 0,   5, 10, 1,   5,  75};
        tbl[4] = '{1, 1, 0,   9, 9,   9, 9,  1, 128, 128};
        tbl[5] = '{0, 0, 1,  30, 1,  40, 1,  1, 128, 128};
        tbl[6] = '{3, 1, 0,  20, 0,  99, 0,  9,  20,  20};
        tbl[7] = '{2, 0, 0,  50, 3,  60, 2,  9, 128, 128};
        tbl[8] = '{2, 1, 0,   0, 1, 200, 0,  9, RND ? 4 : 3, RND ? 4 : 3};

        rst_n = 1'b0;
        b8.start = 1'b0;  b8.mode = '0;  b8.top_avail = 1'b0;  b8.left_avail = 1'b0;
        b8.toppixels = '0; b8.leftpixels = '0; b8.out_ready = 1'b0;
        b4.start = 1'b0;  b4.mode = '0;  b4.top_avail = 1'b0;  b4.left_avail = 1'b0;
        b4.toppixels = '0; b4.leftpixels = '0; b4.out_ready = 1'b0;
        b16.start = 1'b0; b16.mode = '0; b16.top_avail = 1'b0; b16.left_avail = 1'b0;
        b16.toppixels = '0; b16.leftpixels = '0; b16.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        chk("reset_blk4_valid", b4.out_valid, 1'b0);
        chk("reset_blk16_busy", b16.busy, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table, back-to-back so each start lands on the done cycle.
        for (int i = 0; i < 9; i++) begin
            m_mode = tbl[i].mode;
            m_tav  = 1'(tbl[i].tav);
            m_lav  = 1'(tbl[i].lav);
            for (int k = 0; k < 16; k++) begin
                m_top[k]  = (tbl[i].tb + tbl[i].ts * k) & 255;
                m_left[k] = (tbl[i].lb + tbl[i].ls * k) & 255;
            end
            run8(1'b0, 1'b0, tbl[i].lat, p00, p77);
            chk($sformatf("table%0d_pix00", i), p00, tbl[i].p00);
            chk($sformatf("table%0d_pix77", i), p77, tbl[i].p77);
        end

        // Randomized requests with random back-pressure and stray starts.
        for (int i = 0; i < 16; i++) begin
            m_mode = $urandom_range(0, 3);
            m_tav  = 1'($urandom_range(0, 1));
            m_lav  = 1'($urandom_range(0, 1));
            for (int k = 0; k < 16; k++) begin
                m_top[k]  = $urandom_range(0, 255);
                m_left[k] = $urandom_range(0, 255);
            end
            run8(1'b1, 1'($urandom_range(0, 1)), (m_mode >= 2) ? 9 : 1, p00, p77);
        end

        // Abort a vertical block at row 3 and restart.
        @(negedge clk);
        m_mode = 0; m_tav = 1'b1; m_lav = 1'b0;
        for (int k = 0; k < 16; k++) begin
            m_top[k] = 100 + k;
            m_left[k] = 0;
        end
        b8.mode = 2'd0; b8.top_avail = 1'b1; b8.left_avail = 1'b0;
        for (int c = 0; c < 8; c++) b8.toppixels[c*8 +: 8] = 8'(m_top[c]);
        b8.start = 1'b1;
        @(negedge clk);
        b8.start = 1'b0;
        b8.out_ready = 1'b1;
        waited = 0;
        while (!(b8.out_valid && b8.out_row_idx == 3'd3) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("abort_reached_row3", b8.out_row_idx, 3);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort_reset");
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("abort_reset_hold");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_stale_valid", b8.out_valid, 1'b0);
            chk("no_stale_busy", b8.busy, 1'b0);
        end
        b8.out_ready = 1'b0;
        for (int k = 0; k < 16; k++) m_top[k] = 7 * k;
        run8(1'b0, 1'b0, 1, p00, p77);
        chk("restart_pix00", p00, 0);
        chk("restart_pix77", p77, 49);
        @(negedge clk);

        run4(1'b0, 1'b1, RND ? 3 : 2);
        @(negedge clk);
        run4(1'b0, 1'b0, 128);
        @(negedge clk);

        run16_stall();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/intra_pred_nxn.md
INTRA_PRED_NXN -- requirements
Module: intra_pred_nxn

Interface
REQ-001 SHALL have parameter BLK, default 8, block edge in pixels; legal values 4, 8, 16.
REQ-002 SHALL have parameter PW, default 8, pixel bit width.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit, one-cycle request that captures the edges and mode.
REQ-006 SHALL have port mode, input, 2 bits: 0 vertical, 1 horizontal, 2 DC, 3 reserved (treated as DC).
REQ-007 SHALL have ports top_avail and left_avail, input, 1 bit each, edge availability flags.
REQ-008 SHALL have ports toppixels and leftpixels, input, BLK*PW bits each; pixel i occupies bits [i*PW +: PW].
REQ-009 SHALL have port out_row, output, BLK*PW bits, one predicted row; column c occupies bits [c*PW +: PW].
REQ-010 SHALL have ports out_valid (output, 1 bit), out_ready (input, 1 bit), out_row_idx (output, $clog2(BLK) bits) and out_last (output, 1 bit).
REQ-011 SHALL have ports busy (output, 1 bit, high outside IDLE) and done (output, 1 bit, one-cycle pulse).

Function
REQ-012 SHALL implement the states IDLE, ACC and EMIT.
REQ-013 In IDLE, start SHALL register both edges, mode, top_avail and left_avail; the next state SHALL be ACC for DC and EMIT for vertical or horizontal.
REQ-014 start while busy SHALL be ignored, and captured data SHALL NOT change until the block returns to IDLE.
REQ-015 ACC SHALL add top[k] (if top_avail) and left[k] (if left_avail) to an accumulator for k = 0..BLK-1, one k per cycle, for exactly BLK cycles, then go to EMIT.
REQ-016 The accumulator SHALL be PW+$clog2(2*BLK) bits wide, cleared on entry to ACC, and SHALL NOT overflow.
REQ-017 DC value SHALL be sum>>log2(2*BLK) if both edges are available, sum>>log2(BLK) if exactly one is, and 1<<(PW-1) if neither is.
REQ-018 Vertical SHALL set out_row column c = top[c] for every row; if top_avail=0, every pixel SHALL be 1<<(PW-1).
REQ-019 Horizontal SHALL set every column of row r = left[r]; if left_avail=0, every pixel SHALL be 1<<(PW-1).
REQ-020 DC SHALL set every pixel of every row to the DC value.
REQ-021 In EMIT, out_valid SHALL be 1 and rows SHALL be presented as r = 0..BLK-1, with out_row_idx = r.
REQ-022 A row SHALL advance only on a cycle where out_valid and out_ready are both 1.
REQ-023 out_row, out_row_idx and out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 out_last SHALL be 1 exactly when r = BLK-1.
REQ-025 Acceptance of the last row SHALL return the block to IDLE, drop out_valid, and pulse done high in the following cycle.
REQ-026 Latency from start to first out_valid SHALL be 1 cycle for vertical/horizontal and BLK+1 cycles for DC.
REQ-027 With out_ready held at 1, one row SHALL be emitted per cycle.
REQ-028 A start in the same cycle as done SHALL be accepted, since the block is already in IDLE.

Reset
REQ-029 Assertion of reset SHALL immediately force IDLE and zero the accumulator, row counter and captured data, regardless of state, including mid-ACC or mid-EMIT.
REQ-030 During reset, out_row, out_row_idx, out_valid, out_last, busy and done SHALL all be 0.
REQ-031 After reset deasserts, no row from an aborted block SHALL ever be emitted.

Configuration
REQ-032 With macro INTRA_PRED_DC_ROUND_EN defined, each DC shift SHALL add half the divisor first: (sum+BLK)>>log2(2*BLK) for both edges, and (sum+BLK/2)>>log2(BLK) for one edge.
REQ-033 Without INTRA_PRED_DC_ROUND_EN, the DC shifts SHALL truncate with no rounding term.
REQ-034 The macro SHALL NOT affect the vertical/horizontal results or any timing.

Verification
REQ-035 BLK=8, mode=0, top=0..7, top_avail=1, out_ready=1 -> 8 rows in 8 consecutive cycles, each row 0,1,...,7; out_last on row 7; done one cycle later.
REQ-036 BLK=8, mode=2, both edges all 255, both available -> first out_valid 9 cycles after start, every pixel 255; with one edge 10 and the other 11: truncated DC 10, rounded DC 11.
REQ-037 BLK=4, mode=2, top_avail=0, left=1,2,3,4 -> truncated DC 2, rounded DC 3; both flags 0 -> DC 128.
REQ-038 BLK=16, mode=1, left=r*3, out_ready toggling 1,0,1,0 -> rows 0..15 in order, each row stable while stalled, no row dropped or duplicated.
REQ-039 reset asserted during EMIT row 3, then a new start -> all outputs 0 during reset, the new block begins at row 0, and no stale row appears.
REQ-040 start reasserted during ACC and during EMIT -> ignored, and the output matches the first request only.
